// File: rtl/instr_loader.sv
// Boot-time instruction-memory loader: length-framed byte stream in, one byte write per payload byte out.
// Optional trailing checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                state, state_d;
  logic [31:0]           len_q, len_d;
  logic [1:0]            lbyte, lbyte_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [7:0]            mem_wdata_d;
  logic                  accept;
  logic [31:0]           len_full;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            sum, sum_d;
`endif

  // Ready is a pure decode of state so upstream never sees a valid->ready loop.
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
`else
  assign in_ready = (state == S_LEN) || (state == S_DATA);
`endif
  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_q[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN;
      len_q     <= '0;
      lbyte     <= '0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      lbyte     <= lbyte_d;
      cnt       <= cnt_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      done      <= (state_d == S_DONE);
      error     <= (state_d == S_ERR);
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum       <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    len_d       = len_q;
    lbyte_d     = lbyte;
    cnt_d       = cnt;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum_d       = sum;
`endif
    case (state)
      S_LEN: begin
        // Length shifts in from the top so the first (LSB) byte lands in [7:0] after four bytes.
        if (accept) begin
          len_d   = len_full;
          lbyte_d = lbyte + 2'd1;
          if (lbyte == 2'd3) begin
            if (len_full > DEPTH)
              state_d = S_ERR;
            else if (len_full != 32'd0)
              state_d = S_DATA;
            else
`ifdef INSTR_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt[ADDR_WIDTH-1:0];
          mem_wdata_d = in_data;
          cnt_d       = cnt + CNT_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d       = sum + in_data;
`endif
          if (32'(cnt) == len_q - 32'd1)
`ifdef INSTR_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept)
          state_d = (in_data == sum) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

endmodule
